// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when an operation is accepted and parked in a shadow
// register. It is committed to HI/LO after MULT_CYCLES or DIV_CYCLES clocks,
// which reproduces the latency of an iterative unit.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // The counter only ever holds N-1, so clog2(N) bits are enough.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    op_e              op_in;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             res_we_q, res_we_d;
    logic             commit;
    logic             mthi_we;
    logic             mtlo_we;

    // Arithmetic datapath, evaluated on the live operands at the accepting edge.
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign op_in = op_e'(Op);
    assign Busy  = (state_q == S_RUN);

    // Sign-extended operands make the low 64 bits of the product the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide through magnitudes: the quotient truncates toward zero and
    // the remainder takes the dividend's sign. The most negative value divided
    // by -1 wraps to itself with no special case.
    assign a_mag      = A[31] ? (32'd0 - A) : A;
    assign b_mag      = B[31] ? (32'd0 - B) : B;
    // A zero divisor is replaced by 1 so the divider never sees it. That
    // result is discarded, because HI/LO are not written on divide by zero.
    assign b_mag_safe = (B == 32'd0) ? 32'd1 : b_mag;
    assign b_u_safe   = (B == 32'd0) ? 32'd1 : B;
    assign q_mag      = a_mag / b_mag_safe;
    assign r_mag      = a_mag % b_mag_safe;
    assign q_s        = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s        = A[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u        = A / b_u_safe;
    assign r_u        = A % b_u_safe;

    // Next-state, counter and shadow-result logic for the IDLE/RUN controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;
        commit   = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (op_in)
                        OP_MULT: begin
                            state_d  = S_RUN;
                            cnt_d    = MULT_LAST;
                            res_hi_d = prod_s[63:32];
                            res_lo_d = prod_s[31:0];
                            res_we_d = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = S_RUN;
                            cnt_d    = MULT_LAST;
                            res_hi_d = prod_u[63:32];
                            res_lo_d = prod_u[31:0];
                            res_we_d = 1'b1;
                        end
                        OP_DIV: begin
                            state_d  = S_RUN;
                            cnt_d    = DIV_LAST;
                            res_hi_d = r_s;
                            res_lo_d = q_s;
                            res_we_d = (B != 32'd0);
                        end
                        OP_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = DIV_LAST;
                            res_hi_d = r_u;
                            res_lo_d = q_u;
                            res_we_d = (B != 32'd0);
                        end
                        OP_MTHI: mthi_we = 1'b1;
                        OP_MTLO: mtlo_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Start is ignored here. Only the countdown matters.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller state, countdown and shadow result registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the shadow result is reset as well, so an operation cut short by reset cannot leak a write later.
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_we_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
        end
    end

    // Architectural HI/LO: updated by a completing operation or by mthi/mtlo.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            HI <= '0;
            LO <= '0;
        end else if (commit) begin
            if (res_we_q) begin
                HI <= res_hi_q;
                LO <= res_lo_q;
            end
        end else begin
            if (mthi_we) HI <= A;
            if (mtlo_we) LO <= A;
        end
    end

endmodule
